mem_ls_ctrl: RTL and testbench

Parametrised load/store sequencer for the microcontroller's shared-bus datapath. It accepts one LOAD or STORE instruction through a start handshake and latches the instruction fields. It then drives the register-file in/out strobes, PC increment, MAR, MDR and memory enables as a Moore state machine. It waits on the memory-function-complete (mfc) handshake and signals completion with a one-cycle done pulse. Register count, field widths and opcodes are parameters; bad register selects and, optionally, a stuck mfc are reported on err.

---
 rtl/mem_ls_pkg.sv | 37 +++
 rtl/mem_ls_ctrl_if.sv | 40 ++++
 rtl/mem_ls_ctrl_reg_sel_dec.sv | 25 ++
 rtl/mem_ls_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_mem_ls_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_ls_pkg.sv
// Shared types and constants for the load/store sequencer.
// Holds the state enum, default opcodes and instruction field-slicing helpers.
package mem_ls_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    MAR,
    S_DRV,
    S_WR,
    S_WAIT,
    L_WAIT,
    L_CAP,
    L_DRV,
    L_WB,
    DONE
  } state_t;

  localparam int INSTR_W_D = 16;
  localparam int OP_W_D    = 4;
  localparam int FIELD_W_D = 6;
  localparam int NUM_SEL_D = 5;
  localparam int TIMEOUT_D = 16;

  localparam logic [3:0] OP_STORE_D = 4'b0011;
  localparam logic [3:0] OP_LOAD_D  = 4'b0100;

  // Opcode occupies the top OP_W bits, p1 the next FIELD_W bits below it.
  function automatic int op_lsb(int iw, int ow);
    return iw - ow;
  endfunction

  function automatic int p1_lsb(int iw, int ow, int fw);
    return iw - ow - fw;
  endfunction

endpackage

// File: rtl/mem_ls_ctrl_if.sv
// Handshake and datapath-strobe bundle of the load/store sequencer.
// master drives start/instr/mfc; slave (the sequencer) drives all strobes.
interface mem_ls_ctrl_if
  import mem_ls_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_D,
  parameter int NUM_SEL = NUM_SEL_D
);

  logic               start;
  logic [INSTR_W-1:0] instr;
  logic               mfc;
  logic               busy;
  logic               pc_inc;
  logic               mar_en;
  logic               mem_en;
  logic               mem_rw;
  logic               mdr_en_read;
  logic               mdr_en_write;
  logic               mdr_out;
  logic [NUM_SEL-1:0] reg_out;
  logic [NUM_SEL-1:0] reg_in;
  logic               done;
  logic               err;

  modport master (
    output start, instr, mfc,
    input  busy, pc_inc, mar_en, mem_en, mem_rw,
    input  mdr_en_read, mdr_en_write, mdr_out,
    input  reg_out, reg_in, done, err
  );

  modport slave (
    input  start, instr, mfc,
    output busy, pc_inc, mar_en, mem_en, mem_rw,
    output mdr_en_read, mdr_en_write, mdr_out,
    output reg_out, reg_in, done, err
  );

endinterface

// File: rtl/mem_ls_ctrl_reg_sel_dec.sv
// Register-select decoder: FIELD_W code + enable -> NUM_SEL one-hot.
// legal reflects code < NUM_SEL regardless of en; one-hot is zero if illegal.
module reg_sel_dec #(
  parameter int FIELD_W = 6,
  parameter int NUM_SEL = 5
) (
  input  logic [FIELD_W-1:0] code,
  input  logic               en,
  output logic [NUM_SEL-1:0] onehot,
  output logic               legal
);

  localparam logic [FIELD_W:0] LIM = (FIELD_W+1)'(NUM_SEL);

  assign legal = ({1'b0, code} < LIM);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_SEL; i++) begin
      if (en && legal && code == FIELD_W'(i))
        onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_ls_ctrl.sv
// Load/store sequencer: accepts one LOAD/STORE, walks the bus strobes, ends with done/err.
// Ports: clk, rst (async active-low), bus (mem_ls_ctrl_if.slave). Option: MEMLS_TIMEOUT_EN.
module mem_ls_ctrl
  import mem_ls_pkg::*;
#(
  parameter int              INSTR_W     = INSTR_W_D,
  parameter int              OP_W        = OP_W_D,
  parameter int              FIELD_W     = FIELD_W_D,
  parameter int              NUM_SEL     = NUM_SEL_D,
  parameter logic [OP_W-1:0] OP_STORE    = OP_STORE_D,
  parameter logic [OP_W-1:0] OP_LOAD     = OP_LOAD_D,
  parameter int              TIMEOUT_CYC = TIMEOUT_D
) (
  input  logic         clk,
  input  logic         rst,
  mem_ls_ctrl_if.slave bus
);

  localparam int OP_LSB = op_lsb(INSTR_W, OP_W);
  localparam int P1_LSB = p1_lsb(INSTR_W, OP_W, FIELD_W);

  state_t             state;
  state_t             nx;
  logic [OP_W-1:0]    op_q;
  logic [FIELD_W-1:0] p1_q;
  logic [FIELD_W-1:0] p2_q;

  logic [OP_W-1:0]    op_in;
  logic [FIELD_W-1:0] p1_in;
  logic [FIELD_W-1:0] p2_in;

  logic               acc;
  logic               sel_ok;
  logic               err_nx;
  logic               expire;

  logic [FIELD_W-1:0] ro_code;
  logic               ro_en;
  logic [NUM_SEL-1:0] ro_oh;
  logic               ro_legal;
  logic [FIELD_W-1:0] ri_code;
  logic               ri_en;
  logic [NUM_SEL-1:0] ri_oh;
  logic               ri_legal;

  assign op_in = bus.instr[OP_LSB +: OP_W];
  assign p1_in = bus.instr[P1_LSB +: FIELD_W];
  assign p2_in = bus.instr[FIELD_W-1:0];

  assign acc = (state == IDLE) && bus.start &&
               (op_in == OP_LOAD || op_in == OP_STORE);

  // In IDLE the decoders see the raw instr fields so the legality
  // check happens on accept; afterwards they see the latched fields.
  // Code source keys off the current state to keep the loop open.
  assign ro_code = (state == IDLE) ? p2_in :
                   (state == ADDR) ? p2_q  : p1_q;
  assign ri_code = (state == IDLE) ? p1_in : p1_q;

  assign ro_en = (nx == ADDR) || (nx == MAR) ||
                 (nx == S_DRV) || (nx == S_WR);
  assign ri_en = (nx == L_WB);

  assign sel_ok = ro_legal && ri_legal;

  reg_sel_dec #(
    .FIELD_W (FIELD_W),
    .NUM_SEL (NUM_SEL)
  ) u_dec_out (
    .code   (ro_code),
    .en     (ro_en),
    .onehot (ro_oh),
    .legal  (ro_legal)
  );

  reg_sel_dec #(
    .FIELD_W (FIELD_W),
    .NUM_SEL (NUM_SEL)
  ) u_dec_in (
    .code   (ri_code),
    .en     (ri_en),
    .onehot (ri_oh),
    .legal  (ri_legal)
  );

`ifdef MEMLS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] wcnt;

  // Counter holds the number of completed wait cycles; it is zero on
  // the first wait cycle, so expiry falls on wait cycle TIMEOUT_CYC.
  assign expire = (wcnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt <= '0;
    end else if (nx != state) begin
      wcnt <= '0;
    end else if (state == S_WAIT || state == L_WAIT) begin
      wcnt <= wcnt + 1'b1;
    end
  end
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    nx     = state;
    err_nx = 1'b0;
    unique case (state)
      IDLE: begin
        if (acc) begin
          nx     = sel_ok ? ADDR : DONE;
          err_nx = !sel_ok;
        end
      end
      ADDR:  nx = MAR;
      MAR:   nx = (op_q == OP_STORE) ? S_DRV : L_WAIT;
      S_DRV: nx = S_WR;
      S_WR:  nx = S_WAIT;
      S_WAIT: begin
        if (bus.mfc) begin
          nx = DONE;
        end else if (expire) begin
          nx     = DONE;
          err_nx = 1'b1;
        end
      end
      L_WAIT: begin
        if (bus.mfc) begin
          nx = L_CAP;
        end else if (expire) begin
          nx     = DONE;
          err_nx = 1'b1;
        end
      end
      L_CAP: nx = L_DRV;
      L_DRV: nx = L_WB;
      L_WB:  nx = DONE;
      DONE:  nx = IDLE;
      default: nx = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode, so each is a
  // clean Moore function of the state register and latched fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      op_q             <= '0;
      p1_q             <= '0;
      p2_q             <= '0;
      bus.busy         <= 1'b0;
      bus.pc_inc       <= 1'b0;
      bus.mar_en       <= 1'b0;
      bus.mem_en       <= 1'b0;
      bus.mem_rw       <= 1'b0;
      bus.mdr_en_read  <= 1'b0;
      bus.mdr_en_write <= 1'b0;
      bus.mdr_out      <= 1'b0;
      bus.reg_out      <= '0;
      bus.reg_in       <= '0;
      bus.done         <= 1'b0;
      bus.err          <= 1'b0;
    end else begin
      state <= nx;
      if (acc) begin
        op_q <= op_in;
        p1_q <= p1_in;
        p2_q <= p2_in;
      end
      bus.busy         <= (nx != IDLE);
      bus.pc_inc       <= (nx == ADDR);
      bus.mar_en       <= (nx == MAR);
      bus.mem_en       <= (nx == S_WAIT) || (nx == L_WAIT) ||
                          (nx == L_CAP);
      bus.mem_rw       <= (nx == L_WAIT) || (nx == L_CAP);
      bus.mdr_en_read  <= (nx == L_CAP);
      bus.mdr_en_write <= (nx == S_WR);
      bus.mdr_out      <= (nx == L_DRV) || (nx == L_WB);
      bus.reg_out      <= ro_oh;
      bus.reg_in       <= ri_oh;
      bus.done         <= (nx == DONE);
      bus.err          <= err_nx;
    end
  end

endmodule

// File: tb/tb_mem_ls_ctrl.sv
// Randomized bench for mem_ls_ctrl against a per-cycle expected-output model.
// Honours MEMLS_TIMEOUT_EN when defined (TIMEOUT_CYC = 4).
module tb_mem_ls_ctrl;
  import mem_ls_pkg::*;

  localparam int IW = 16;
  localparam int NS = 5;
  localparam int TO = 4;
  localparam int VW = 10 + 2 * NS;
`ifdef MEMLS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef logic [VW-1:0] vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  vec_t exp_q[$];

  mem_ls_ctrl_if #(.INSTR_W(IW), .NUM_SEL(NS)) bus ();

  mem_ls_ctrl #(
    .INSTR_W     (IW),
    .OP_W        (4),
    .FIELD_W     (6),
    .NUM_SEL     (NS),
    .OP_STORE    (4'b0011),
    .OP_LOAD     (4'b0100),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t got_vec();
    return {bus.busy, bus.pc_inc, bus.mar_en, bus.mem_en,
            bus.mem_rw, bus.mdr_en_read, bus.mdr_en_write,
            bus.mdr_out, bus.done, bus.err & bus.done,
            bus.reg_out, bus.reg_in};
  endfunction

  task automatic chk(string tag, vec_t got, vec_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic vec_t mk(bit b, bit pc, bit mar, bit men,
                              bit mrw, bit mrd, bit mwr, bit mout,
                              bit dn, bit er, int ro, int ri);
    logic [NS-1:0] o;
    logic [NS-1:0] i;
    o = '0;
    i = '0;
    if (ro >= 0) o[ro] = 1'b1;
    if (ri >= 0) i[ri] = 1'b1;
    return {b, pc, mar, men, mrw, mrd, mwr, mout, dn, er, o, i};
  endfunction

  // Expected outputs for cycles 1..N after the start cycle, ending
  // with one idle cycle. w = number of wait cycles with mfc low.
  function automatic void build(logic [3:0] op, int p1, int p2, int w);
    bit to;
    int nw;
    exp_q.delete();
    if (op != OP_STORE_D && op != OP_LOAD_D) begin
      repeat (21) exp_q.push_back('0);
      return;
    end
    if (p1 >= NS || p2 >= NS) begin
      exp_q.push_back(mk(1,0,0,0,0,0,0,0,1,1,-1,-1));
      exp_q.push_back('0);
      return;
    end
    to = TO_EN && (w >= TO);
    nw = to ? TO : w + 1;
    exp_q.push_back(mk(1,1,0,0,0,0,0,0,0,0,p2,-1));
    exp_q.push_back(mk(1,0,1,0,0,0,0,0,0,0,p2,-1));
    if (op == OP_STORE_D) begin
      exp_q.push_back(mk(1,0,0,0,0,0,0,0,0,0,p1,-1));
      exp_q.push_back(mk(1,0,0,0,0,0,1,0,0,0,p1,-1));
      repeat (nw) exp_q.push_back(mk(1,0,0,1,0,0,0,0,0,0,-1,-1));
    end else begin
      repeat (nw) exp_q.push_back(mk(1,0,0,1,1,0,0,0,0,0,-1,-1));
      if (!to) begin
        exp_q.push_back(mk(1,0,0,1,1,1,0,0,0,0,-1,-1));
        exp_q.push_back(mk(1,0,0,0,0,0,0,1,0,0,-1,-1));
        exp_q.push_back(mk(1,0,0,0,0,0,0,1,0,0,-1,p1));
      end
    end
    exp_q.push_back(mk(1,0,0,0,0,0,0,0,1,to,-1,-1));
    exp_q.push_back('0);
  endfunction

  task automatic run_op(string name, logic [IW-1:0] ins, int w);
    logic [3:0] op;
    bit         bad;
    int         ws;
    int         n;
    op  = ins[15:12];
    bad = (op != OP_STORE_D) && (op != OP_LOAD_D);
    ws  = (op == OP_STORE_D) ? 5 : 3;
    build(op, int'(ins[11:6]), int'(ins[5:0]), w);
    n = exp_q.size();
    @(negedge clk);
    chk({name, " c0"}, got_vec(), '0);
    bus.start = 1'b1;
    bus.instr = ins;
    bus.mfc   = 1'($urandom % 2);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      chk($sformatf("%s c%0d", name, k), got_vec(), exp_q[k-1]);
      if (bad) begin
        bus.start = (k < n);
      end else begin
        bus.start = (k < n) ? 1'($urandom % 2) : 1'b0;
        bus.instr = IW'($urandom);
      end
      if (k == ws + w)
        bus.mfc = 1'b1;
      else if (k < ws || k > ws + w)
        bus.mfc = 1'($urandom % 2);
      else
        bus.mfc = 1'b0;
    end
    bus.start = 1'b0;
  endtask

  task automatic reset_mid_load();
    build(4'b0100, 4, 3, 50);
    @(negedge clk);
    chk("rstld c0", got_vec(), '0);
    bus.start = 1'b1;
    bus.instr = 16'h4103;
    bus.mfc   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("rstld c%0d", k), got_vec(), exp_q[k-1]);
      bus.start = 1'b0;
      bus.mfc   = 1'b0;
    end
    #2 rst = 1'b0;
    #1 chk("rst_async", got_vec(), '0);
    @(negedge clk);
    chk("rst_hold", got_vec(), '0);
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]    op;
    logic [IW-1:0] ins;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.instr = '0;
    bus.mfc   = 1'b0;
    #2 chk("reset", got_vec(), '0);
    @(negedge clk);
    rst = 1'b1;

    run_op("st3042", 16'h3042, 2);
    run_op("ld4103", 16'h4103, 0);
    run_op("ill3005", 16'h3005, 0);
    run_op("ill3142", 16'h3142, 0);
    run_op("badop", 16'h1042, 0);
    run_op("ld_w4", 16'h4020, 4);
`ifdef MEMLS_TIMEOUT_EN
    run_op("tmo_ld", 16'h4103, 1000);
    run_op("tmo_st", 16'h3042, 1000);
`endif
    reset_mid_load();
    run_op("st_after_rst", 16'h3042, 1);

    for (int t = 0; t < 40; t++) begin
      case ($urandom % 8)
        0, 1, 2: op = 4'b0011;
        3, 4, 5: op = 4'b0100;
        default: begin
          op = 4'($urandom % 16);
          if (op == 4'b0011 || op == 4'b0100) op = 4'b0001;
        end
      endcase
      ins = {op, 6'($urandom_range(0, 6)), 6'($urandom_range(0, 6))};
      run_op($sformatf("rnd%0d", t), ins, $urandom_range(0, 5));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
